// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file access sequencer.
// Optional feature macro: REGFILE_WB_BYPASS_EN (writeback-to-operand forwarding).
package regfile_seq_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    // x0 always reads as zero, whatever the register file returns.
    function automatic logic [XLEN-1:0] zero_src(input logic [AW-1:0] rs,
                                                 input logic [XLEN-1:0] val);
        return (rs == REG_ZERO) ? '0 : val;
    endfunction

endpackage

// File: rtl/regfile_access_sequencer_arbiter.sv
// Port arbiter for the single shared register-file port: one read or one
// write per cycle. A pending writeback preempts the operand read once; the
// yield_rd flag then guarantees the read wins the next ISSUE cycle.
// Optional feature macro handled elsewhere: REGFILE_WB_BYPASS_EN.
module regfile_port_arbiter
    import regfile_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_issue_i,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            wb_ready_o,
    output logic            read_grant_o,
    output logic            yield_rd_o,
    output logic            rf_read_en_o,
    output logic [AW-1:0]   rf_read_1_o,
    output logic [AW-1:0]   rf_read_2_o,
    output logic [AW-1:0]   rf_write_en_o,
    output logic [XLEN-1:0] rf_data_in_o
);

    logic yield_rd_q, yield_rd_d;
    logic wb_fire;
    logic write_grant;

    // Grant decode; every port output is forced quiet while reset is high.
    always_comb begin
        wb_ready_o    = !reset && (!in_issue_i || !yield_rd_q);
        wb_fire       = wb_ready_o && wb_valid_i;
        read_grant_o  = !reset && in_issue_i && (yield_rd_q || !wb_valid_i);
        write_grant   = wb_fire && (wb_rd_i != REG_ZERO);
        rf_read_en_o  = read_grant_o;
        rf_read_1_o   = (!reset && in_issue_i) ? rs1_i : REG_ZERO;
        rf_read_2_o   = (!reset && in_issue_i) ? rs2_i : REG_ZERO;
        rf_write_en_o = write_grant ? wb_rd_i : REG_ZERO;
        rf_data_in_o  = write_grant ? wb_data_i : '0;
        yield_rd_d    = yield_rd_q;
        if (in_issue_i && wb_fire) begin
            yield_rd_d = 1'b1;
        end
        if (read_grant_o) begin
            yield_rd_d = 1'b0;
        end
    end

    // Yield flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            yield_rd_q <= 1'b0;
        end else begin
            yield_rd_q <= yield_rd_d;
        end
    end

    assign yield_rd_o = yield_rd_q;

endmodule

// File: rtl/regfile_access_sequencer.sv
// Initiator-side sequencer for the 32x64 user register file: accepts operand
// fetches and writebacks, drives the shared register-file port, and holds the
// fetched operands until execute takes them.
// Optional feature macro: REGFILE_WB_BYPASS_EN forwards writeback data into
// operands captured after the read was issued.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and the offering side keeps its
// payload stable until the transfer.
module regfile_access_sequencer
    import regfile_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    input  logic [AW-1:0]   req_rd,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [AW-1:0]   op_rd,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            rf_read_en,
    output logic [AW-1:0]   rf_read_1,
    output logic [AW-1:0]   rf_read_2,
    output logic [AW-1:0]   rf_write_en,
    output logic [XLEN-1:0] rf_data_in,
    input  logic [XLEN-1:0] rf_data_out_1,
    input  logic [XLEN-1:0] rf_data_out_2,
    output logic [1:0]      dbg_state,
    output logic            dbg_yield_rd
);

    seq_state_e      state_q;
    logic [AW-1:0]   rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] op_a_q, op_b_q;
    logic            op_valid_q;
    logic            read_grant;
    logic            fwd_a, fwd_b;
    logic [XLEN-1:0] cap_a, cap_b;

    regfile_port_arbiter u_arb (
        .clk          (clk),
        .reset        (reset),
        .in_issue_i   (state_q == ISSUE),
        .rs1_i        (rs1_q),
        .rs2_i        (rs2_q),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .wb_ready_o   (wb_ready),
        .read_grant_o (read_grant),
        .yield_rd_o   (dbg_yield_rd),
        .rf_read_en_o (rf_read_en),
        .rf_read_1_o  (rf_read_1),
        .rf_read_2_o  (rf_read_2),
        .rf_write_en_o(rf_write_en),
        .rf_data_in_o (rf_data_in)
    );

    // Request acceptance: from IDLE, or from HOLD while the held pair retires.
    always_comb begin
        req_ready = !reset && ((state_q == IDLE) || ((state_q == HOLD) && op_ready));
    end

    // Operand capture values, with optional writeback forwarding on a source match.
    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        if (wb_valid && wb_ready && (wb_rd != REG_ZERO) &&
            ((state_q == WAIT) || (state_q == HOLD))) begin
            fwd_a = (wb_rd == rs1_q);
            fwd_b = (wb_rd == rs2_q);
        end
`endif
        cap_a = fwd_a ? wb_data : zero_src(rs1_q, rf_data_out_1);
        cap_b = fwd_b ? wb_data : zero_src(rs2_q, rf_data_out_2);
    end

    // Sequencer FSM with registered operand outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rs1_q      <= REG_ZERO;
            rs2_q      <= REG_ZERO;
            rd_q       <= REG_ZERO;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rs1_q   <= req_rs1;
                        rs2_q   <= req_rs2;
                        rd_q    <= req_rd;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (read_grant) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    op_a_q     <= cap_a;
                    op_b_q     <= cap_b;
                    op_valid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (fwd_a) begin
                        op_a_q <= wb_data;
                    end
                    if (fwd_b) begin
                        op_b_q <= wb_data;
                    end
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        if (req_valid) begin
                            rs1_q   <= req_rs1;
                            rs2_q   <= req_rs2;
                            rd_q    <= req_rd;
                            state_q <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_rd     = rd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Self-checking bench for regfile_access_sequencer with a behavioural
// register file and an architectural register mirror as reference.
module tb_regfile_access_sequencer;
    import regfile_seq_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid, req_ready;
    logic [AW-1:0]   req_rs1, req_rs2, req_rd;
    logic            op_valid, op_ready;
    logic [XLEN-1:0] op_a, op_b;
    logic [AW-1:0]   op_rd;
    logic            wb_valid, wb_ready;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            rf_read_en;
    logic [AW-1:0]   rf_read_1, rf_read_2, rf_write_en;
    logic [XLEN-1:0] rf_data_in, rf_data_out_1, rf_data_out_2;
    logic [1:0]      dbg_state;
    logic            dbg_yield_rd;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] rf_mem [32];
    logic [XLEN-1:0] model_regs [32];

    // Clock
    always #5 clk = ~clk;

    regfile_access_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_read_en(rf_read_en), .rf_read_1(rf_read_1), .rf_read_2(rf_read_2),
        .rf_write_en(rf_write_en), .rf_data_in(rf_data_in),
        .rf_data_out_1(rf_data_out_1), .rf_data_out_2(rf_data_out_2),
        .dbg_state(dbg_state), .dbg_yield_rd(dbg_yield_rd)
    );

    function automatic logic [XLEN-1:0] junk(input int i);
        return 64'hDEAD_BEEF_0000_0000 | 64'(i);
    endfunction

    // Behavioural register file: registered reads, filled with junk on reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= junk(i);
        end else begin
            if (rf_write_en != 5'd0) rf_mem[rf_write_en] <= rf_data_in;
            if (rf_read_en) begin
                rf_data_out_1 <= rf_mem[rf_read_1];
                rf_data_out_2 <= rf_mem[rf_read_2];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = junk(i);
    endtask

    function automatic logic [XLEN-1:0] exp_src(input logic [AW-1:0] rs);
        return (rs == 5'd0) ? 64'd0 : model_regs[rs];
    endfunction

    // Writeback while the sequencer is idle: accepted immediately.
    task automatic wb_idle(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        logic [AW-1:0]   exp_en;
        logic [XLEN-1:0] exp_d;
        exp_en = rd;
        exp_d  = (rd != 5'd0) ? data : 64'd0;
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        @(negedge clk);
        checks++;
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_ready_idle: got %b expected 1", wb_ready); end
        checks++;
        if (rf_write_en !== exp_en) begin errors++; $display("FAIL wb_write_en: got %0d expected %0d", rf_write_en, exp_en); end
        checks++;
        if (rf_data_in !== exp_d) begin errors++; $display("FAIL wb_data_in: got %h expected %h", rf_data_in, exp_d); end
        tick();
        wb_valid = 1'b0;
        if (rd != 5'd0) model_regs[rd] = data;
    endtask

    // Issue a fetch from IDLE and wait for op_valid; returns at the negedge it shows.
    task automatic start_fetch(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic [AW-1:0] rd, input bit wb_issue,
                               input logic [AW-1:0] wrd, input logic [XLEN-1:0] wdata,
                               output logic [XLEN-1:0] ea, output logic [XLEN-1:0] eb);
        int c;
        int lat_exp;
        bit seen;
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready); end
        tick();
        req_valid = 1'b0;
        if (wb_issue) begin wb_valid = 1'b1; wb_rd = wrd; wb_data = wdata; end
        lat_exp = wb_issue ? 4 : 3;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            if (wb_issue && c == 1) begin
                checks++;
                if (wb_ready !== 1'b1 || rf_read_en !== 1'b0 || rf_write_en !== wrd) begin
                    errors++;
                    $display("FAIL issue_preempt: got wb_ready=%b read_en=%b write_en=%0d expected 1 0 %0d",
                             wb_ready, rf_read_en, rf_write_en, wrd);
                end
            end
            if (op_valid === 1'b1) seen = 1'b1;
            else begin
                tick();
                if (wb_issue && c == 1) begin
                    wb_valid = 1'b0;
                    if (wrd != 5'd0) model_regs[wrd] = wdata;
                end
            end
        end
        checks++;
        if (!seen || c != lat_exp) begin errors++; $display("FAIL latency: got %0d cycles expected %0d", c, lat_exp); end
        ea = exp_src(rs1);
        eb = exp_src(rs2);
        checks++;
        if (op_a !== ea) begin errors++; $display("FAIL op_a: got %h expected %h", op_a, ea); end
        checks++;
        if (op_b !== eb) begin errors++; $display("FAIL op_b: got %h expected %h", op_b, eb); end
        checks++;
        if (op_rd !== rd) begin errors++; $display("FAIL op_rd: got %0d expected %0d", op_rd, rd); end
    endtask

    // Stall in HOLD, then retire the operands; returns at posedge+1 in IDLE.
    task automatic finish_fetch(input int stall, input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb);
        for (int s = 0; s < stall; s++) begin
            tick();
            @(negedge clk);
            checks++;
            if (op_valid !== 1'b1 || op_a !== ea || op_b !== eb || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall: got valid=%b a=%h b=%h req_ready=%b expected 1 %h %h 0",
                         op_valid, op_a, op_b, req_ready, ea, eb);
            end
        end
        tick();
        op_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_req_ready: got %b expected 1", req_ready); end
        tick();
        op_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL retire: got op_valid=%b expected 0", op_valid); end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd4; req_rd = 5'd1;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h1234;
        op_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || wb_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got req=%b wb=%b expected 0 0", req_ready, wb_ready);
        end
        checks++;
        if (rf_read_en !== 1'b0 || rf_read_1 !== 5'd0 || rf_read_2 !== 5'd0 ||
            rf_write_en !== 5'd0 || rf_data_in !== 64'd0) begin
            errors++; $display("FAIL reset_rf: got rd_en=%b r1=%0d r2=%0d we=%0d din=%h expected all 0",
                               rf_read_en, rf_read_1, rf_read_2, rf_write_en, rf_data_in);
        end
        checks++;
        if (op_valid !== 1'b0 || op_a !== 64'd0 || op_b !== 64'd0 || op_rd !== 5'd0) begin
            errors++; $display("FAIL reset_op: got v=%b a=%h b=%h rd=%0d expected 0", op_valid, op_a, op_b, op_rd);
        end
        checks++;
        if (dbg_state !== 2'(IDLE) || dbg_yield_rd !== 1'b0) begin
            errors++; $display("FAIL reset_state: got %0d yield=%b expected %0d 0", dbg_state, dbg_yield_rd, IDLE);
        end
        tick();
        reset = 1'b0; req_valid = 1'b0; wb_valid = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_basic_fetch();
        logic [XLEN-1:0] ea, eb;
        wb_idle(5'd5, 64'hA);
        wb_idle(5'd6, 64'hB);
        start_fetch(5'd5, 5'd6, 5'd7, 1'b0, 5'd0, 64'd0, ea, eb);
        finish_fetch(0, ea, eb);
    endtask

    task automatic test_preempt();
        logic [XLEN-1:0] ea, eb;
        start_fetch(5'd5, 5'd6, 5'd8, 1'b1, 5'd5, 64'h55, ea, eb);
        checks++;
        if (ea !== 64'h55) begin errors++; $display("FAIL preempt_order: got %h expected 55", ea); end
        finish_fetch(0, ea, eb);
    endtask

    task automatic test_wb_zero();
        logic [XLEN-1:0] ea, eb;
        wb_idle(5'd0, 64'hFF);
        start_fetch(5'd0, 5'd0, 5'd2, 1'b0, 5'd0, 64'd0, ea, eb);
        finish_fetch(0, ea, eb);
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] ea, eb;
        start_fetch(5'd6, 5'd5, 5'd9, 1'b0, 5'd0, 64'd0, ea, eb);
        finish_fetch(5, ea, eb);
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] ea, eb, want;
        start_fetch(5'd5, 5'd6, 5'd7, 1'b0, 5'd0, 64'd0, ea, eb);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h99;
        @(negedge clk);
        checks++;
        if (wb_ready !== 1'b1 || rf_write_en !== 5'd5) begin
            errors++; $display("FAIL hold_wb: got ready=%b we=%0d expected 1 5", wb_ready, rf_write_en);
        end
        tick();
        wb_valid = 1'b0;
        model_regs[5] = 64'h99;
`ifdef REGFILE_WB_BYPASS_EN
        want = 64'h99;
`else
        want = ea;
`endif
        @(negedge clk);
        checks++;
        if (op_a !== want) begin errors++; $display("FAIL hold_bypass: got %h expected %h", op_a, want); end
        finish_fetch(0, want, eb);
        start_fetch(5'd5, 5'd5, 5'd1, 1'b0, 5'd0, 64'd0, ea, eb);
        finish_fetch(0, ea, eb);
    endtask

    task automatic test_reset_in_wait();
        logic [XLEN-1:0] ea, eb;
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6; req_rd = 5'd3;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'hBAD;
        @(negedge clk);
        checks++;
        if (rf_read_en !== 1'b0 || rf_write_en !== 5'd0 || rf_data_in !== 64'd0 ||
            rf_read_1 !== 5'd0 || rf_read_2 !== 5'd0 || wb_ready !== 1'b0) begin
            errors++; $display("FAIL reset_wait_rf: got rd_en=%b we=%0d din=%h r1=%0d r2=%0d wb_ready=%b expected 0",
                               rf_read_en, rf_write_en, rf_data_in, rf_read_1, rf_read_2, wb_ready);
        end
        tick();
        reset = 1'b0;
        wb_valid = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b0 || op_a !== 64'd0 || req_ready !== 1'b1 || dbg_state !== 2'(IDLE)) begin
            errors++; $display("FAIL reset_wait_restart: got v=%b a=%h req_ready=%b st=%0d expected 0 0 1 %0d",
                               op_valid, op_a, req_ready, dbg_state, IDLE);
        end
        tick();
        start_fetch(5'd5, 5'd9, 5'd4, 1'b0, 5'd0, 64'd0, ea, eb);
        finish_fetch(0, ea, eb);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]   r1_q[$], r2_q[$], rdq[$];
        logic [XLEN-1:0] exp_q_a[$], exp_q_b[$];
        logic [AW-1:0]   exp_q_rd[$];
        int n, sent, got, cyc, last;
        bit hs;
        n = 8; sent = 0; got = 0; cyc = 0; last = -1;
        for (int i = 0; i < n; i++) begin
            r1_q.push_back(5'($urandom_range(0, 31)));
            r2_q.push_back(5'($urandom_range(0, 31)));
            rdq.push_back(5'($urandom_range(0, 31)));
        end
        op_ready = 1'b1;
        req_valid = 1'b1; req_rs1 = r1_q[0]; req_rs2 = r2_q[0]; req_rd = rdq[0];
        while (got < n && cyc < 80) begin
            @(negedge clk);
            cyc++;
            hs = req_valid && req_ready;
            if (op_valid === 1'b1) begin
                checks++;
                if (exp_q_a.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious: got op_valid=1 expected no pending operands");
                end else begin
                    if (op_a !== exp_q_a[0] || op_b !== exp_q_b[0] || op_rd !== exp_q_rd[0]) begin
                        errors++; $display("FAIL b2b_data: got %h %h %0d expected %h %h %0d",
                                           op_a, op_b, op_rd, exp_q_a[0], exp_q_b[0], exp_q_rd[0]);
                    end
                    void'(exp_q_a.pop_front()); void'(exp_q_b.pop_front()); void'(exp_q_rd.pop_front());
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", cyc - last); end
                end
                last = cyc;
                got++;
            end
            tick();
            if (hs) begin
                exp_q_a.push_back(exp_src(r1_q[sent]));
                exp_q_b.push_back(exp_src(r2_q[sent]));
                exp_q_rd.push_back(rdq[sent]);
                sent++;
                if (sent < n) begin
                    req_rs1 = r1_q[sent]; req_rs2 = r2_q[sent]; req_rd = rdq[sent];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        checks++;
        if (got != n) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got, n); end
        op_ready = 1'b0;
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [XLEN-1:0] ea, eb;
        for (int it = 0; it < 15; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                wb_idle(5'($urandom_range(0, 31)), {$urandom, $urandom});
            end
            start_fetch(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), {$urandom, $urandom}, ea, eb);
            finish_fetch(int'($urandom_range(0, 3)), ea, eb);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_rd = '0; wb_rd = '0; wb_data = '0;
        test_reset();
        test_basic_fetch();
        test_preempt();
        test_wb_zero();
        test_stall();
        test_bypass();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
